// File: rtl/ne_coeff_buf.sv
// ne_coeff_buf: 32-row x 512-bit coefficient buffer, lane-wise writes, full-row reads, 2-cycle read latency
//   clk              : rising-edge clock
//   rst              : synchronous active-low reset
//   coeff_buf_en     : access strobe, one access per asserted cycle
//   coeff_buf_we     : 1 = write lane, 0 = read row
//   coeff_buf_addr   : [8:4] row, [3:0] lane
//   coeff_buf_din    : 32-bit lane write data
//   coeff_buf_dout   : 512-bit read row, held between reads
//   coeff_buf_rvalid : one-cycle pulse marking fresh dout
//   coeff_buf_ready  : high once the post-reset zero-fill completes
//   coeff_buf_err    : sticky, set by any access during zero-fill
module ne_coeff_buf #(
    parameter int ROWS  = 32,
    parameter int LANES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  coeff_buf_en,
    input  logic                  coeff_buf_we,
    input  logic [8:0]            coeff_buf_addr,
    input  logic [31:0]           coeff_buf_din,
    output logic [LANES*32-1:0]   coeff_buf_dout,
    output logic                  coeff_buf_rvalid,
    output logic                  coeff_buf_ready,
    output logic                  coeff_buf_err
);
    typedef enum logic {INIT, RUN} state_t;

    state_t              state_q, state_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [LANES*32-1:0] mem_q [ROWS];
    logic [LANES*32-1:0] rd_q, dout_q;
    logic                rd_v_q, rvalid_q, err_q;
    logic [4:0]          row;
    logic [3:0]          lane;
    logic                run, acc_wr, acc_rd;

    assign row    = coeff_buf_addr[8:4];
    assign lane   = coeff_buf_addr[3:0];
    assign run    = state_q == RUN;
    assign acc_wr = run && coeff_buf_en && coeff_buf_we;
    assign acc_rd = run && coeff_buf_en && !coeff_buf_we;

    always_comb begin
        state_d = (state_q == INIT && cnt_q == 5'(ROWS - 1)) ? RUN : state_q;
        cnt_d   = (state_q == INIT) ? cnt_q + 5'd1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= INIT;
            cnt_q    <= '0;
            rd_v_q   <= 1'b0;
            rvalid_q <= 1'b0;
            dout_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_v_q   <= acc_rd;
            rvalid_q <= rd_v_q;
            dout_q   <= rd_v_q ? rd_q : dout_q;
            err_q    <= err_q | (!run && coeff_buf_en);
        end
    end

    // Zero-fill shares the array write port; no reset on the array itself.
    always_ff @(posedge clk) begin
        if (rst && !run)
            mem_q[cnt_q] <= '0;
        else if (acc_wr)
            mem_q[row][{lane, 5'd0} +: 32] <= coeff_buf_din;
        if (acc_rd)
            rd_q <= mem_q[row];
    end

    assign coeff_buf_dout   = dout_q;
    assign coeff_buf_rvalid = rvalid_q;
    assign coeff_buf_ready  = run;
    assign coeff_buf_err    = err_q;
endmodule

// File: tb/tb_ne_coeff_buf.sv
// tb_ne_coeff_buf: scoreboard bench for ne_coeff_buf with directed vectors
module tb_ne_coeff_buf;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         we = 1'b0;
    logic [8:0]   addr = '0;
    logic [31:0]  din = '0;
    logic [511:0] dout;
    logic         rvalid, ready, err;

    logic [511:0] exp_q[$];
    logic [511:0] model [32];
    int           pass_cnt = 0;
    int           total = 0;

    ne_coeff_buf dut (
        .clk(clk), .rst(rst), .coeff_buf_en(en), .coeff_buf_we(we),
        .coeff_buf_addr(addr), .coeff_buf_din(din), .coeff_buf_dout(dout),
        .coeff_buf_rvalid(rvalid), .coeff_buf_ready(ready), .coeff_buf_err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] expv);
        total++;
        if (act === expv) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    always @(negedge clk) begin
        if (rvalid) begin
            if (exp_q.size() == 0) chk("unexpected_rvalid", 512'd1, 512'd0);
            else chk("read_data", dout, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [8:0] a, input logic [31:0] d);
        en = 1'b1; we = 1'b1; addr = a; din = d;
        model[a[8:4]][{a[3:0], 5'd0} +: 32] = d;
        tick();
        en = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [8:0] a);
        en = 1'b1; we = 1'b0; addr = a;
        exp_q.push_back(model[a[8:4]]);
        tick();
        en = 1'b0;
    endtask

    // Counts edges with rst high until ready rises; optional read poke on INIT edge 3.
    task automatic wait_ready(input bit poke);
        int n = 0;
        while (!ready && n < 100) begin
            if (poke && n == 2) en = 1'b1;
            tick();
            en = 1'b0;
            n++;
            if (poke && n == 3) chk("err_set_in_init", 512'(err), 512'd1);
        end
        chk("init_cycles", 512'(n), 512'd32);
        for (int r = 0; r < 32; r++) model[r] = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        chk("rst_dout", dout, 512'd0);
        chk("rst_flags", {509'd0, rvalid, ready, err}, 512'd0);
        rst = 1'b1;
    endtask

    initial begin
        logic [511:0] e;
        do_reset();
        chk("ready_low_init", 512'(ready), 512'd0);
        wait_ready(1'b0);
        chk("err_clean", 512'(err), 512'd0);
        rd(9'h000);
        rd(9'h1F0);
        repeat (3) tick();

        wr(9'h035, 32'hDEADBEEF);
        rd(9'h030);
        repeat (3) tick();
        e = '0;
        e[191:160] = 32'hDEADBEEF;
        chk("hand_row3", dout, e);

        wr(9'h1FF, 32'hA5A5_0001);
        wr(9'h1F0, 32'h0000_0F0F);
        rd(9'h1F7);
        for (int r = 0; r < 8; r++) wr(9'(r << 4), 32'h100 + r);
        for (int r = 0; r < 8; r++) rd(9'(r << 4) | 9'(r));
        repeat (4) tick();
        e = '0;
        e[31:0] = 32'h107;
        chk("hold_row7", dout, e);
        chk("hold_rvalid", 512'(rvalid), 512'd0);

        rd(9'h020);
        wr(9'h020, 32'h1234_5678);
        rd(9'h020);
        repeat (4) tick();

        do_reset();
        wait_ready(1'b1);
        chk("err_sticky", 512'(err), 512'd1);
        do_reset();
        wait_ready(1'b0);

        wr(9'h044, 32'hCAFE_F00D);
        en = 1'b1; we = 1'b0; addr = 9'h040;
        tick();
        en = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("drop_dout", dout, 512'd0);
        chk("drop_ready", 512'(ready), 512'd0);
        wait_ready(1'b0);
        rd(9'h044);
        repeat (4) tick();
        chk("queue_drained", 512'(exp_q.size()), 512'd0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule

// File: doc/ne_coeff_buf.md
NE_COEFF_BUF -- requirements
Module: ne_coeff_buf

Interface
REQ-001 SHALL have parameter ROWS, 32, number of 512-bit coefficient rows (fixed; sets the row field addr[8:4]).
REQ-002 SHALL have parameter LANES, 16, number of 32-bit words per row (fixed; sets the lane field addr[3:0]).
REQ-003 SHALL have port clk  input  1  sole clock; all logic samples on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset; sampled on the clk rising edge.
REQ-005 SHALL have port coeff_buf_en  input  1  access strobe from the arbiter; one access per asserted cycle.
REQ-006 SHALL have port coeff_buf_we  input  1  1 = write, 0 = read; qualified by coeff_buf_en.
REQ-007 SHALL have port coeff_buf_addr  input  9  addr[8:4] = row, addr[3:0] = lane.
REQ-008 SHALL have port coeff_buf_din  input  32  write data for one lane.
REQ-009 SHALL have port coeff_buf_dout  output  512  read row; lane k occupies bits [32k+31:32k].
REQ-010 SHALL have port coeff_buf_rvalid  output  1  single-cycle pulse; coeff_buf_dout is valid for this read.
REQ-011 SHALL have port coeff_buf_ready  output  1  1 = initialisation complete and accesses accepted.
REQ-012 SHALL have port coeff_buf_err  output  1  sticky flag; set when an access arrives while not ready.

Function
REQ-013 SHALL implement a two-state FSM, INIT and RUN; rst low forces INIT with row counter = 0.
REQ-014 In INIT, SHALL zero one row per cycle at the row counter, then increment; after row 31 is zeroed, SHALL enter RUN (32 INIT cycles after rst deasserts).
REQ-015 coeff_buf_ready SHALL be 0 in INIT and 1 in RUN, registered and rising in the first RUN cycle.
REQ-016 In INIT, any cycle with coeff_buf_en=1 SHALL be ignored (no write, no rvalid) and SHALL set coeff_buf_err on the next edge.
REQ-017 coeff_buf_err SHALL stay set until reset; no other condition clears it.
REQ-018 In RUN, en=1 and we=1 SHALL write din into lane addr[3:0] of row addr[8:4] at that edge; other lanes are unchanged.
REQ-019 In RUN, en=1 and we=0 SHALL read row addr[8:4]; addr[3:0] is ignored.
REQ-020 Read latency SHALL be exactly 2 cycles: read issued in cycle N gives rvalid=1 with the row data on dout in cycle N+2.
REQ-021 Read path SHALL be two register stages (array read register, then output register), fully pipelined; one read per cycle gives one rvalid per cycle.
REQ-022 coeff_buf_dout SHALL hold the last read data while rvalid=0; rvalid SHALL be 1 only for the cycle its data is first presented.
REQ-023 A read issued the cycle after a write to the same row SHALL return the newly written lane (no stale data).
REQ-024 A write issued while earlier reads are in the pipeline SHALL NOT change data already captured by those reads.
REQ-025 coeff_buf_we SHALL be don't-care when coeff_buf_en=0; such cycles cause no state change.
REQ-026 All 512 address values SHALL be legal; there is no out-of-range condition.

Reset
REQ-027 While rst=0: coeff_buf_dout=0, rvalid=0, ready=0, err=0, FSM=INIT, row counter=0, read pipeline flushed.
REQ-028 Reset asserted mid-operation SHALL drop in-flight reads (no rvalid after reset) and SHALL re-run the full 32-cycle zero-fill.
REQ-029 Stored contents SHALL NOT be relied on across reset; every row reads 0 after INIT completes.

Verification
REQ-030 Release rst, hold en=0 -> ready=0 for 32 cycles then 1; read rows 0 and 31 -> dout=0, rvalid 2 cycles after each request.
REQ-031 RUN: write lane 5 row 3 (addr=0x035) with din=0xDEADBEEF, read addr=0x030 next cycle -> dout[191:160]=0xDEADBEEF, all other bits 0, rvalid in cycle +2.
REQ-032 RUN: issue back-to-back reads of rows 0..7 in 8 consecutive cycles -> 8 consecutive rvalid pulses, row order preserved, dout holds row 7 afterwards.
REQ-033 Assert en=1 (read) in the 3rd INIT cycle -> no rvalid, err=1 from the next cycle, err still 1 after ready rises.
REQ-034 Issue a read, assert rst=0 the next cycle for 1 cycle -> no rvalid appears, dout=0, ready=0, and ready returns 32 cycles after rst deasserts.
